alarm_ring_controller: RTL and testbench
========================================

# alarm_ring_controller

Sequences the alarm output of the clock: detects the moment current time reaches the programmed alarm time while the mode state machine is in normal mode, drives the buzzer for a bounded ring period, and handles snooze and stop requests with a limited snooze budget. Sits between the time/alarm registers, the mode state machine and the buzzer/LED driver; all inputs are synchronous to the system clock.

## Interface
- RING_SECONDS, 60: ring duration in seconds before auto-stop (≥1).
- SNOOZE_MINUTES, 5: snooze delay in minutes (≥1).
- MAX_SNOOZE, 3: snoozes allowed per alarm event (1–3).

- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- tick_1hz  in  1  one-cycle pulse per second.
- mode  in  2  mode state: 0 normal, 1 time setting, 2 alarm setting, 3 treated as non-normal.
- cur_hour / cur_min / cur_sec  in  5/6/6  current time, binary.
- alm_hour / alm_min  in  5/6  alarm time, binary.
- alarm_enable  in  1  level; alarm armed.
- snooze_btn / stop_btn  in  1 each  debounced one-cycle pulses.
- buzzer  out  1  buzzer drive.
- ringing  out  1  high in RINGING.
- snoozed  out  1  high in SNOOZE.
- snooze_left  out  2  remaining snoozes.

## Operation
- States: IDLE, RINGING, SNOOZE. Reset: IDLE, buzzer=0, ringing=0, snoozed=0, snooze_left=MAX_SNOOZE, ring/snooze counters 0, match_q=1.
- match = (cur_hour==alm_hour)&&(cur_min==alm_min)&&(cur_sec==0); match_q is match registered every cycle. trigger = match && !match_q && mode==0 && alarm_enable. match_q reset to 1 means a match present at reset does not ring.
- cancel = !alarm_enable || mode!=0. Priority each cycle: cancel > stop_btn > snooze_btn > counter expiry.
- IDLE: trigger -> RINGING, ring counter=0, snooze_left=MAX_SNOOZE.
- RINGING: tick_1hz increments ring counter; counter reaching RING_SECONDS -> IDLE. snooze_btn with snooze_left>0 -> SNOOZE, snooze_left-1, snooze counter=SNOOZE_MINUTES*60; with snooze_left==0 ignored. stop_btn or cancel -> IDLE, snooze_left=MAX_SNOOZE.
- SNOOZE: tick_1hz decrements snooze counter; decrement to 0 -> RINGING, ring counter=0. snooze_btn ignored. stop_btn or cancel -> IDLE, snooze_left=MAX_SNOOZE.
- Trigger in RINGING/SNOOZE ignored (cannot occur within one minute).
- Button and tick in the same cycle: button transition taken, tick not counted.
- Counter widths: $clog2(RING_SECONDS+1) and $clog2(SNOOZE_MINUTES*60+1); no wrap.

## Timing
- All outputs registered; state, ringing, snoozed, buzzer change on the edge that samples the causing input (1-cycle latency from input to output).
- Trigger: match first true at cycle n -> ringing=1, buzzer=1 from edge n+1.
- Ring auto-stop on the edge sampling the RING_SECONDS-th tick after entry.
- Snooze re-ring on the edge sampling the SNOOZE_MINUTES*60-th tick after snooze.
- Reset asserted mid-ring or mid-snooze: IDLE with reset values on next edge; held reset overrides every input.

## Configuration
- ALARM_BEEP_PATTERN_EN defined: in RINGING, buzzer starts at 1 on entry and toggles on every tick_1hz (1 s on / 1 s off); 0 outside RINGING.
- Undefined: buzzer == ringing (steady tone).

## Test plan
- Alarm 07:30, enable=1, mode=0, time steps 07:29:59 -> 07:30:00 -> ringing=1, buzzer=1 next edge; after 60 ticks ringing=0, state IDLE.
- Ringing, snooze_btn -> snoozed=1, snooze_left=2; after 300 ticks ringing=1; repeat 3 snoozes -> 4th snooze_btn ignored, snooze_left=0, stays RINGING.
- Ringing, stop_btn and snooze_btn same cycle -> IDLE, snooze_left=3, snoozed=0.
- Time set to alarm time with mode=1 -> no ring; mode=0 in SNOOZE then alarm_enable=0 -> IDLE next edge.
- Reset asserted while time equals alarm (sec 0) -> after release no ring; reset during RINGING -> all outputs at reset values next edge.
- With ALARM_BEEP_PATTERN_EN: buzzer sequence 1,0,1,0 across first four ticks of RINGING; without: buzzer constant 1.

Source files
------------

// File: rtl/alarm_ring_controller.sv
// alarm_ring_controller
//   Detects the rising edge of "current time == alarm time" (at second 0)
//   while in normal mode with the alarm armed, then sequences the buzzer
//   through ring / snooze / stop with a bounded snooze budget.
//
// Ports
//   clock, reset            system clock, synchronous active-high reset
//   tick_1hz                one-cycle pulse per second
//   mode[1:0]               0 normal, anything else cancels / blocks the alarm
//   cur_hour/min/sec        current time (binary)
//   alm_hour/min            alarm time (binary)
//   alarm_enable            alarm armed (level)
//   snooze_btn, stop_btn    debounced one-cycle pulses
//   buzzer                  buzzer drive
//   ringing, snoozed        state indicators
//   snooze_left[1:0]        snoozes remaining for this alarm event
//
// Build option
//   ALARM_BEEP_PATTERN_EN   when defined the buzzer beeps 1 s on / 1 s off while
//                           ringing; otherwise the buzzer follows ringing.
module alarm_ring_controller #(
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_MINUTES = 5,
  parameter int MAX_SNOOZE     = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic [1:0] mode,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  input  logic [4:0] alm_hour,
  input  logic [5:0] alm_min,
  input  logic       alarm_enable,
  input  logic       snooze_btn,
  input  logic       stop_btn,
  output logic       buzzer,
  output logic       ringing,
  output logic       snoozed,
  output logic [1:0] snooze_left
);

  localparam int SNZ_TICKS = SNOOZE_MINUTES * 60;
  localparam int RW        = $clog2(RING_SECONDS + 1);
  localparam int SW        = $clog2(SNZ_TICKS + 1);

  localparam logic [RW-1:0] RING_LAST = RW'(RING_SECONDS - 1);
  localparam logic [SW-1:0] SNZ_LOAD  = SW'(SNZ_TICKS);
  localparam logic [SW-1:0] SNZ_ONE   = SW'(1);
  localparam logic [1:0]    LEFT_MAX  = 2'(MAX_SNOOZE);

  typedef enum logic [1:0] {IDLE = 2'd0, RINGING = 2'd1, SNOOZE = 2'd2} state_t;

  state_t        state, state_d;
  logic [RW-1:0] ring_cnt, ring_d;
  logic [SW-1:0] snz_cnt, snz_d;
  logic [1:0]    left_q, left_d;
  logic          match_q;

  logic match, trigger, cancel;

  // Ring only on the first cycle of a match; match_q resets high so a match
  // already present when reset releases is not treated as a new event.
  assign match   = (cur_hour == alm_hour) && (cur_min == alm_min) && (cur_sec == 6'd0);
  assign trigger = match && !match_q && (mode == 2'd0) && alarm_enable;
  assign cancel  = !alarm_enable || (mode != 2'd0);

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      ring_cnt <= '0;
      snz_cnt  <= '0;
      left_q   <= LEFT_MAX;
      match_q  <= 1'b1;
    end else begin
      state    <= state_d;
      ring_cnt <= ring_d;
      snz_cnt  <= snz_d;
      left_q   <= left_d;
      match_q  <= match;
    end
  end

  // Priority: cancel > stop > snooze > tick. A button that causes a
  // transition swallows a coincident tick.
  always_comb begin
    state_d = state;
    ring_d  = ring_cnt;
    snz_d   = snz_cnt;
    left_d  = left_q;
    case (state)
      IDLE: begin
        if (trigger) begin
          state_d = RINGING;
          ring_d  = '0;
          left_d  = LEFT_MAX;
        end
      end
      RINGING: begin
        if (cancel || stop_btn) begin
          state_d = IDLE;
          left_d  = LEFT_MAX;
        end else if (snooze_btn && (left_q != 2'd0)) begin
          state_d = SNOOZE;
          left_d  = left_q - 2'd1;
          snz_d   = SNZ_LOAD;
        end else if (tick_1hz) begin
          ring_d = ring_cnt + RW'(1);
          if (ring_cnt == RING_LAST) state_d = IDLE;
        end
      end
      SNOOZE: begin
        if (cancel || stop_btn) begin
          state_d = IDLE;
          left_d  = LEFT_MAX;
        end else if (tick_1hz) begin
          snz_d = snz_cnt - SW'(1);
          if (snz_cnt == SNZ_ONE) begin
            state_d = RINGING;
            ring_d  = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ringing     = (state == RINGING);
  assign snoozed     = (state == SNOOZE);
  assign snooze_left = left_q;

`ifdef ALARM_BEEP_PATTERN_EN
  // Beep phase: forced to 1 on every entry to RINGING, toggled by each tick
  // that leaves us in RINGING, cleared elsewhere.
  logic buzz_q;
  always_ff @(posedge clock) begin
    if (reset)                   buzz_q <= 1'b0;
    else if (state_d != RINGING) buzz_q <= 1'b0;
    else if (state != RINGING)   buzz_q <= 1'b1;
    else if (tick_1hz)           buzz_q <= ~buzz_q;
  end
  assign buzzer = buzz_q;
`else
  assign buzzer = ringing;
`endif

endmodule

// File: tb/tb_alarm_ring_controller.sv
// Directed bench for alarm_ring_controller (default parameters).
// Expected outputs are queued as each step is driven and checked once the
// DUT has clocked that step.
module tb_alarm_ring_controller;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       tick_1hz = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [4:0] cur_hour = 5'd7, alm_hour = 5'd7;
  logic [5:0] cur_min = 6'd29, cur_sec = 6'd59, alm_min = 6'd30;
  logic       alarm_enable = 1'b1;
  logic       snooze_btn = 1'b0, stop_btn = 1'b0;
  logic       buzzer, ringing, snoozed;
  logic [1:0] snooze_left;

`ifdef ALARM_BEEP_PATTERN_EN
  localparam bit BEEP = 1'b1;
`else
  localparam bit BEEP = 1'b0;
`endif

  alarm_ring_controller dut (
    .clock(clock), .reset(reset), .tick_1hz(tick_1hz), .mode(mode),
    .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
    .alm_hour(alm_hour), .alm_min(alm_min), .alarm_enable(alarm_enable),
    .snooze_btn(snooze_btn), .stop_btn(stop_btn),
    .buzzer(buzzer), .ringing(ringing), .snoozed(snoozed), .snooze_left(snooze_left)
  );

  always #5 clock = ~clock;

  typedef struct {
    string      tag;
    logic [4:0] v;   // {ringing, snoozed, buzzer, snooze_left}
    bit         chk_bz;
  } exp_t;

  exp_t q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check_all();
    while (q.size() > 0) begin
      exp_t       e;
      logic [4:0] obs;
      logic [4:0] ex;
      e   = q.pop_front();
      obs = {ringing, snoozed, buzzer, snooze_left};
      ex  = e.v;
      if (!e.chk_bz) begin
        obs[2] = 1'b0;
        ex[2]  = 1'b0;
      end
      n_assert++;
      assert (obs === ex) else begin
        n_fail++;
        $error("FAIL %s: got ring/snz/bz/left=%b, expected %b", e.tag, obs, ex);
      end
    end
  endtask

  // Push expectation for the step currently driven, clock it, then compare.
  // In the beep build the buzzer is only checked by the dedicated beep steps.
  task automatic step(input string tag, input bit r, input bit s, input logic [1:0] l);
    q.push_back('{tag, {r, s, r, l}, !BEEP});
    cyc();
    check_all();
  endtask

  task automatic step_bz(input string tag, input bit r, input bit bz, input logic [1:0] l);
    q.push_back('{tag, {r, 1'b0, bz, l}, 1'b1});
    cyc();
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_1hz = 1'b1; cyc();
      tick_1hz = 1'b0; cyc();
    end
  endtask

  task automatic ring_up(input string tag);
    cur_min = 6'd29; cur_sec = 6'd59; cyc();
    cur_min = 6'd30; cur_sec = 6'd0;
    step(tag, 1, 0, 2'd3);
    cur_sec = 6'd1;
  endtask

  task automatic press_snooze(input string tag, input bit r, input bit s, input logic [1:0] l);
    snooze_btn = 1'b1;
    step(tag, r, s, l);
    snooze_btn = 1'b0;
  endtask

  initial begin
    // Reset with the time sitting on the alarm: must not ring afterwards.
    cur_min = 6'd30; cur_sec = 6'd0;
    cyc();
    step("reset_state", 0, 0, 2'd3);
    reset = 1'b0;
    step("no_ring_after_reset", 0, 0, 2'd3);
    step("no_ring_after_reset2", 0, 0, 2'd3);
    cur_sec = 6'd1; cyc();

    // Alarm time reached outside normal mode: no ring, even when mode returns.
    mode = 2'd1;
    cur_min = 6'd29; cur_sec = 6'd59; cyc();
    cur_min = 6'd30; cur_sec = 6'd0;
    step("mode1_no_ring", 0, 0, 2'd3);
    mode = 2'd0;
    step("mode0_late_no_ring", 0, 0, 2'd3);
    cur_sec = 6'd1; cyc();

    // Basic ring and auto-stop after 60 ticks.
    ring_up("trigger");
    ticks(59);
    step("ring_59_ticks", 1, 0, 2'd3);
    tick_1hz = 1'b1;
    step("auto_stop", 0, 0, 2'd3);
    tick_1hz = 1'b0;
    step("idle_after_stop", 0, 0, 2'd3);

    // Snooze budget.
    ring_up("trigger2");
    press_snooze("snooze1", 0, 1, 2'd2);
    ticks(299);
    step("snooze_299", 0, 1, 2'd2);
    tick_1hz = 1'b1;
    step("rering1", 1, 0, 2'd2);
    tick_1hz = 1'b0;
    press_snooze("snooze2", 0, 1, 2'd1);
    ticks(300);
    step("rering2", 1, 0, 2'd1);
    press_snooze("snooze3", 0, 1, 2'd0);
    ticks(300);
    step("rering3", 1, 0, 2'd0);
    press_snooze("snooze4_ignored", 1, 0, 2'd0);
    ticks(59);
    step("rering_59_ticks", 1, 0, 2'd0);
    ticks(1);
    step("rering_auto_stop", 0, 0, 2'd0);

    // Stop and snooze in the same cycle: stop wins.
    ring_up("trigger3");
    stop_btn = 1'b1; snooze_btn = 1'b1;
    step("stop_beats_snooze", 0, 0, 2'd3);
    stop_btn = 1'b0; snooze_btn = 1'b0;

    // Disable while snoozed cancels; tick coincident with snooze is swallowed.
    ring_up("trigger4");
    ticks(2);
    tick_1hz = 1'b1;
    press_snooze("snooze_with_tick", 0, 1, 2'd2);
    tick_1hz = 1'b0;
    ticks(299);
    step("snooze_full_299", 0, 1, 2'd2);
    alarm_enable = 1'b0;
    step("disable_in_snooze", 0, 0, 2'd3);
    alarm_enable = 1'b1;

    // Reset while ringing.
    ring_up("trigger5");
    press_snooze("snooze_before_reset", 0, 1, 2'd2);
    ticks(300);
    step("ringing_before_reset", 1, 0, 2'd2);
    reset = 1'b1;
    step("reset_mid_ring", 0, 0, 2'd3);
    reset = 1'b0;
    step("idle_after_reset", 0, 0, 2'd3);

    // Buzzer pattern across the first ticks of a ring.
    ring_up("trigger6");
    step_bz("buzz_entry", 1, 1'b1, 2'd3);
    tick_1hz = 1'b1;
    step_bz("buzz_tick1", 1, BEEP ? 1'b0 : 1'b1, 2'd3);
    step_bz("buzz_tick2", 1, 1'b1, 2'd3);
    step_bz("buzz_tick3", 1, BEEP ? 1'b0 : 1'b1, 2'd3);
    tick_1hz = 1'b0;
    stop_btn = 1'b1;
    step_bz("buzz_off_on_stop", 0, 1'b0, 2'd3);
    stop_btn = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
